// File: rtl/deserialize_10b.sv
// deserialize_10b: receive-side framer that locks 10-bit word boundaries onto K28.5 commas.
// Define DESER_LOCK_TIMEOUT_EN to drop lock after LOCK_TIMEOUT boundary words without a comma.
module deserialize_10b #(
    parameter int unsigned RELOCK_COUNT = 3,
    parameter int unsigned LOCK_TIMEOUT = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [9:0] d_out,
    output logic       d_valid,
    output logic       comma,
    output logic       locked
);

    localparam int unsigned WORD_W     = 10;
    localparam int unsigned PH_W       = 4;
    localparam int unsigned FILL_W     = 4;
    localparam int unsigned LAST_PHASE = WORD_W - 1;
    localparam int unsigned MIS_W      = $clog2(RELOCK_COUNT + 1);
    localparam int unsigned TO_W       = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [6:0] CORE_NEG = 7'b1111100;
    localparam logic [6:0] CORE_POS = 7'b0000011;

    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   sr_q, sr_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [MIS_W-1:0]    mis_q, mis_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [WORD_W-1:0]   d_out_q, d_out_d;
    logic                d_valid_q, d_valid_d;
    logic                comma_q, comma_d;
    logic                locked_q, locked_d;

    logic [WORD_W-1:0]   sr_shift;
    logic [FILL_W-1:0]   fill_inc;
    logic [PH_W-1:0]     phase_inc;
    logic [MIS_W-1:0]    mis_inc;
    logic                match;
    logic                boundary;
`ifdef DESER_LOCK_TIMEOUT_EN
    logic [TO_W-1:0]     to_inc;
`endif

    // Next-state: shift, phase tracking, alignment decisions and word emission.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        phase_d   = phase_q;
        fill_d    = fill_q;
        mis_d     = mis_q;
        to_d      = to_q;
        d_out_d   = d_out_q;
        d_valid_d = 1'b0;
        comma_d   = comma_q;
        locked_d  = locked_q;

        sr_shift  = {bit_in, sr_q[WORD_W-1:1]};
        fill_inc  = (fill_q == FILL_W'(WORD_W)) ? fill_q : fill_q + 1'b1;
        phase_inc = (phase_q == PH_W'(LAST_PHASE)) ? '0 : phase_q + 1'b1;
        mis_inc   = (mis_q == MIS_W'(RELOCK_COUNT)) ? mis_q : mis_q + 1'b1;
        boundary  = (phase_inc == '0);
        match     = (fill_inc == FILL_W'(WORD_W)) &&
                    ((sr_shift[6:0] == CORE_NEG) || (sr_shift[6:0] == CORE_POS));
`ifdef DESER_LOCK_TIMEOUT_EN
        to_inc    = to_q + 1'b1;
`endif

        if (bit_valid) begin
            sr_d    = sr_shift;
            fill_d  = fill_inc;
            phase_d = phase_inc;
            case (state_q)
                UNLOCKED: begin
                    if (match) begin
                        state_d   = LOCKED;
                        locked_d  = 1'b1;
                        phase_d   = '0;
                        d_out_d   = sr_shift;
                        comma_d   = 1'b1;
                        d_valid_d = 1'b1;
                    end
                end
                LOCKED: begin
                    if (boundary) begin
                        if (match) begin
                            mis_d     = '0;
                            to_d      = '0;
                            d_out_d   = sr_shift;
                            comma_d   = 1'b1;
                            d_valid_d = 1'b1;
                        end else begin
`ifdef DESER_LOCK_TIMEOUT_EN
                            if (to_inc == TO_W'(LOCK_TIMEOUT)) begin
                                state_d  = UNLOCKED;
                                locked_d = 1'b0;
                                mis_d    = '0;
                                to_d     = '0;
                            end else begin
                                to_d      = to_inc;
                                d_out_d   = sr_shift;
                                comma_d   = 1'b0;
                                d_valid_d = 1'b1;
                            end
`else
                            d_out_d   = sr_shift;
                            comma_d   = 1'b0;
                            d_valid_d = 1'b1;
`endif
                        end
                    end else if (match) begin
                        // Enough commas at a new phase: move the boundary onto them.
                        if (mis_inc == MIS_W'(RELOCK_COUNT)) begin
                            phase_d   = '0;
                            mis_d     = '0;
                            d_out_d   = sr_shift;
                            comma_d   = 1'b1;
                            d_valid_d = 1'b1;
                        end else begin
                            mis_d = mis_inc;
                        end
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= UNLOCKED;
            sr_q      <= '0;
            phase_q   <= '0;
            fill_q    <= '0;
            mis_q     <= '0;
            to_q      <= '0;
            d_out_q   <= '0;
            d_valid_q <= 1'b0;
            comma_q   <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            phase_q   <= phase_d;
            fill_q    <= fill_d;
            mis_q     <= mis_d;
            to_q      <= to_d;
            d_out_q   <= d_out_d;
            d_valid_q <= d_valid_d;
            comma_q   <= comma_d;
            locked_q  <= locked_d;
        end
    end

    assign d_out   = d_out_q;
    assign d_valid = d_valid_q;
    assign comma   = comma_q;
    assign locked  = locked_q;

endmodule
